master_in_port: RTL and testbench

//  Master-side serial receive port of the system bus. Deserialises the 1-bit, LSB-first read-data

---
 rtl/master_in_port.sv | 115 +++++++++++
 tb/tb_master_in_port.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/master_in_port.sv
// master_in_port
//   Master-side serial receive port of the system bus. Rebuilds DATA_WIDTH-bit
//   words from the 1-bit, LSB-first read-data stream sent by the slave output
//   port. A transfer carries one word or a contiguous burst of words. This port
//   owns the master half of the read-data handshake.
//
// Handshake (valid/ready): a transfer starts on the rising edge where
//   master_ready and slave_valid are both 1. master_ready is high only in IDLE
//   while rx_en is high and reset is low. Once RECEIVE is entered, no further
//   handshake is taken until the last word of the burst completes. The first
//   serial bit is sampled on the edge after the handshake edge.
//
// Ports
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   rx_en         master wants read data (sampled only in IDLE)
//   burst_len     words in the transfer, latched at handshake (0 means 1)
//   slave_valid   slave has read data ready to send
//   master_ready  handshake ready (combinational)
//   rx_data       serial read data, LSB first, one bit per clock
//   dataout       last fully received word, held until the next word completes
//   data_valid    one-cycle pulse: dataout updated this cycle
//   rx_done       one-cycle pulse together with data_valid of the final word
//   word_count    words completed in the current or last transfer
//   bit_count     index of the next bit to sample (debug)
//   rx_state      current FSM state encoding (debug)
module master_in_port #(
    parameter int DATA_WIDTH = 8,
    parameter int BURST_W    = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx_en,
    input  logic [BURST_W-1:0]    burst_len,
    input  logic                  slave_valid,
    output logic                  master_ready,
    input  logic                  rx_data,
    output logic [DATA_WIDTH-1:0] dataout,
    output logic                  data_valid,
    output logic                  rx_done,
    output logic [BURST_W-1:0]    word_count,
    output logic [2:0]            bit_count,
    output logic [1:0]            rx_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECEIVE = 2'd1
    } state_t;

    localparam logic [2:0]         BIT_LAST = 3'(DATA_WIDTH - 1);
    localparam logic [BURST_W-1:0] ONE      = BURST_W'(1);

    state_t                state;
    state_t                state_next;

    // Only the lower DATA_WIDTH-1 bits of a word are stored here. The top bit
    // is the rx_data sample that completes the word.
    logic [DATA_WIDTH-2:0] shift;
    logic [DATA_WIDTH-1:0] shift_full;
    logic [BURST_W-1:0]    len;
    logic [BURST_W-1:0]    word_count_inc;
    logic                  handshake;
    logic                  word_last;
    logic                  final_word;

    assign master_ready   = (state == IDLE) && rx_en && !reset;
    assign handshake      = master_ready && slave_valid;
    assign shift_full     = {rx_data, shift};
    assign word_last      = (state == RECEIVE) && (bit_count == BIT_LAST);
    assign word_count_inc = word_count + ONE;
    assign final_word     = word_last && (word_count_inc == len);
    assign rx_state       = state;

    always_comb begin
        state_next = IDLE;
        case (state)
            IDLE:    state_next = handshake  ? RECEIVE : IDLE;
            RECEIVE: state_next = final_word ? IDLE    : RECEIVE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            shift      <= '0;
            len        <= ONE;
            dataout    <= '0;
            data_valid <= 1'b0;
            rx_done    <= 1'b0;
            word_count <= '0;
            bit_count  <= '0;
        end else begin
            state      <= state_next;
            data_valid <= 1'b0;
            rx_done    <= 1'b0;
            if (handshake) begin
                len        <= (burst_len == '0) ? ONE : burst_len;
                bit_count  <= '0;
                word_count <= '0;
            end else if (state == RECEIVE) begin
                shift     <= shift_full[DATA_WIDTH-1:1];
                bit_count <= bit_count + 3'd1;
                if (word_last) begin
                    dataout    <= shift_full;
                    data_valid <= 1'b1;
                    word_count <= word_count_inc;
                    rx_done    <= final_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_master_in_port.sv
// Testbench for master_in_port: a cycle-driven reference model derived from the
// transfer timing rules, table-driven single-word transfers, hand-written
// multi-cycle sequences, random traffic and one maximum-length burst.
module tb_master_in_port;

    logic        clk;
    logic        reset;
    logic        rx_en;
    logic [11:0] burst_len;
    logic        slave_valid;
    logic        master_ready;
    logic        rx_data;
    logic [7:0]  dataout;
    logic        data_valid;
    logic        rx_done;
    logic [11:0] word_count;
    logic [2:0]  bit_count;
    logic [1:0]  rx_state;

    master_in_port #(.DATA_WIDTH(8), .BURST_W(12)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_en       (rx_en),
        .burst_len   (burst_len),
        .slave_valid (slave_valid),
        .master_ready(master_ready),
        .rx_data     (rx_data),
        .dataout     (dataout),
        .data_valid  (data_valid),
        .rx_done     (rx_done),
        .word_count  (word_count),
        .bit_count   (bit_count),
        .rx_state    (rx_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: a transfer is described by its handshake cycle and
    // length; every output is derived from the cycle distance to that point.
    logic       bits_mem [0:49999];
    int         cnum = 0;
    logic       m_active = 1'b0;
    int         m_hs_t = 0;
    int         m_len = 1;
    logic [7:0] m_dout = 8'h00;
    logic       m_dv = 1'b0;
    logic       m_done = 1'b0;
    int         m_wc = 0;
    int         m_bc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cnum);
        end
    endtask

    // One clock cycle: drive inputs, check master_ready, clock, update model, check outputs.
    task automatic cyc(input logic en, input logic sv, input logic rst, input logic rxd,
                       input logic [11:0] bl);
        logic       exp_mr;
        logic       hs;
        int         d;
        int         k;
        logic [7:0] w;
        rx_en       = en;
        slave_valid = sv;
        reset       = rst;
        rx_data     = rxd;
        burst_len   = bl;
        bits_mem[cnum] = rxd;
        #1;
        exp_mr = !m_active && en && !rst;
        check("master_ready", {31'd0, master_ready}, {31'd0, exp_mr});
        hs = exp_mr && sv;
        @(posedge clk);
        #1;
        cnum++;
        m_dv   = 1'b0;
        m_done = 1'b0;
        if (rst) begin
            m_active = 1'b0;
            m_dout   = 8'h00;
            m_wc     = 0;
            m_bc     = 0;
        end else if (hs) begin
            m_active = 1'b1;
            m_hs_t   = cnum - 1;
            m_len    = (bl == 12'd0) ? 1 : int'(bl);
            m_wc     = 0;
            m_bc     = 0;
        end else if (m_active) begin
            d    = cnum - 1 - m_hs_t;
            m_bc = d % 8;
            if (d % 8 == 0) begin
                k = d / 8 - 1;
                for (int j = 0; j < 8; j++) w[j] = bits_mem[m_hs_t + 1 + 8 * k + j];
                m_dout = w;
                m_dv   = 1'b1;
                m_wc   = k + 1;
                if (m_wc == m_len) begin
                    m_done   = 1'b1;
                    m_active = 1'b0;
                end
            end
        end
        check("dataout",    {24'd0, dataout},    {24'd0, m_dout});
        check("data_valid", {31'd0, data_valid}, {31'd0, m_dv});
        check("rx_done",    {31'd0, rx_done},    {31'd0, m_done});
        check("word_count", {20'd0, word_count}, 32'(m_wc));
        check("bit_count",  {29'd0, bit_count},  32'(m_bc));
        check("rx_state",   {30'd0, rx_state},   m_active ? 32'd1 : 32'd0);
    endtask

    // Eight serial bits of one word, LSB first; handshake inputs toggle randomly
    // because they must be ignored while receiving.
    task automatic send_bits(input logic [7:0] w);
        for (int j = 0; j < 8; j++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, w[j],
                12'($urandom_range(0, 7)));
    endtask

    task automatic xfer_word(input logic [11:0] bl, input logic [7:0] w);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, bl);
        send_bits(w);
    endtask

    typedef struct {
        logic [11:0] bl;
        logic [7:0]  word;
        logic [7:0]  exp_dout;
    } vec_t;

    vec_t tbl [6];

    initial begin
        tbl[0] = '{bl: 12'd1, word: 8'hA5, exp_dout: 8'hA5};
        tbl[1] = '{bl: 12'd0, word: 8'h3C, exp_dout: 8'h3C};
        tbl[2] = '{bl: 12'd1, word: 8'h00, exp_dout: 8'h00};
        tbl[3] = '{bl: 12'd1, word: 8'hFF, exp_dout: 8'hFF};
        tbl[4] = '{bl: 12'd0, word: 8'h81, exp_dout: 8'h81};
        tbl[5] = '{bl: 12'd1, word: 8'h5A, exp_dout: 8'h5A};

        reset       = 1'b1;
        rx_en       = 1'b0;
        slave_valid = 1'b0;
        rx_data     = 1'b0;
        burst_len   = 12'd0;
        @(posedge clk);
        #1;

        // Reset state
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 12'd3);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 12'd0);
        check("reset_dataout",  {24'd0, dataout},    32'd0);
        check("reset_state",    {30'd0, rx_state},   32'd0);
        check("reset_wc",       {20'd0, word_count}, 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);

        // Single-word transfers (burst_len 0 behaves as 1)
        for (int i = 0; i < 6; i++) begin
            xfer_word(tbl[i].bl, tbl[i].word);
            check("tbl_dataout", {24'd0, dataout},    {24'd0, tbl[i].exp_dout});
            check("tbl_valid",   {31'd0, data_valid}, 32'd1);
            check("tbl_done",    {31'd0, rx_done},    32'd1);
            check("tbl_wc",      {20'd0, word_count}, 32'd1);
            check("tbl_state",   {30'd0, rx_state},   32'd0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
            check("tbl_pulse_end", {31'd0, data_valid | rx_done}, 32'd0);
        end

        // Three-word burst
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'd3);
        send_bits(8'h01);
        check("burst_w0", {23'd0, data_valid, dataout}, {23'd0, 1'b1, 8'h01});
        check("burst_w0_done", {31'd0, rx_done}, 32'd0);
        send_bits(8'hFF);
        check("burst_w1", {23'd0, data_valid, dataout}, {23'd0, 1'b1, 8'hFF});
        check("burst_w1_done", {31'd0, rx_done}, 32'd0);
        send_bits(8'h3C);
        check("burst_w2", {23'd0, data_valid, dataout}, {23'd0, 1'b1, 8'h3C});
        check("burst_w2_done", {31'd0, rx_done}, 32'd1);
        check("burst_wc", {20'd0, word_count}, 32'd3);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        check("burst_wc_hold", {20'd0, word_count}, 32'd3);

        // Back-to-back transfers: second handshake in the rx_done cycle
        xfer_word(12'd1, 8'hC3);
        check("b2b_first", {24'd0, dataout}, 32'hC3);
        xfer_word(12'd1, 8'h5A);
        check("b2b_second", {24'd0, dataout}, 32'h5A);
        check("b2b_done", {31'd0, rx_done}, 32'd1);

        // Reset in the middle of a two-word burst
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'd2);
        for (int j = 0; j < 4; j++) cyc(1'b1, 1'b0, 1'b0, 1'b1, 12'd0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 12'd0);
        check("midrst_dataout", {24'd0, dataout},  32'd0);
        check("midrst_state",   {30'd0, rx_state}, 32'd0);
        check("midrst_pulse",   {30'd0, data_valid, rx_done}, 32'd0);
        reset = 1'b0;
        #1;
        check("midrst_ready", {31'd0, master_ready}, 32'd1);
        for (int j = 0; j < 12; j++) cyc(1'b0, 1'b1, 1'b0, 1'b1, 12'd2);

        // rx_en low: slave_valid must be ignored
        for (int j = 0; j < 20; j++)
            cyc(1'b0, 1'b1, 1'b0, 1'($urandom_range(0, 1)), 12'($urandom_range(0, 4)));
        check("rxen_low_state", {30'd0, rx_state}, 32'd0);

        // Random traffic with occasional resets
        for (int j = 0; j < 3000; j++)
            cyc(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 1)),
                12'($urandom_range(0, 4)));

        // Maximum-length burst completes without counter wrap
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        for (int j = 0; j < 10 && rx_state != 2'd0; j++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 12'd4095);
        for (int j = 0; j < 4095 * 8; j++)
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0,
                1'($urandom_range(0, 1)), 12'($urandom_range(0, 7)));
        check("max_wc",   {20'd0, word_count}, 32'd4095);
        check("max_done", {31'd0, rx_done},    32'd1);
        for (int j = 0; j < 5; j++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 12'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
